conv_mult_scheduler: RTL and testbench
======================================

Name: conv_mult_scheduler

Overview:
Sequences one full convolution layer pass over a shared pool of NMULT window-multiplier units. It walks every output window origin (channel k, row, col) with stride S and issues one window job per cycle to the lowest-indexed free multiplier. It tracks per-unit busy state from done pulses and signals completion once every job has been issued and retired. It replaces the combinational assignment loop in the conv control path with a registered, cycle-accurate dispatcher.

Parameters:
N, 8, input feature map side (pixels)
F, 3, filter side
S, 1, stride (padding fixed at 0)
K, 3, channels per filter
NMULT, 8, multiplier units in pool
MID_W, 3, multiplier id width, equal to clog2(NMULT)
CW, 16, row/col coordinate width
IDX_W, 24, linear job index width

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  begin a layer pass; sampled only in IDLE
abort  in  1  cancel pass; return to IDLE next cycle
mult_done  in  NMULT  one-cycle per-unit completion pulses
mult_start  out  NMULT  one-hot, one-cycle job launch to unit
disp_mid  out  MID_W  id of unit in mult_start
disp_k  out  CW  channel of dispatched window
disp_row  out  CW  top-left row of dispatched window
disp_col  out  CW  top-left col of dispatched window
disp_idx  out  IDX_W  linear job index (k*OUT*OUT + row_i*OUT + col_i)
busy  out  1  high in DISPATCH or DRAIN
done  out  1  one-cycle pulse when pass completes
jobs_retired  out  IDX_W  count of accepted mult_done pulses this pass
err_spurious  out  1  sticky: mult_done seen on an idle unit

Behaviour:
- OUT = (N-F)/S + 1. TOTAL = OUT*OUT*K. Defaults: OUT=6, TOTAL=108.
- All outputs are registered. Reset values: all outputs 0, busy mask 0, counters 0, state IDLE.
- States:
  - IDLE: start=1 -> DISPATCH; clear counters, busy mask and err_spurious.
  - DISPATCH: each cycle with at least one free unit, issue one job. Last job issued -> DRAIN.
  - DRAIN: wait until the busy mask is 0 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Dispatch timing:
  - start sampled at edge e0 -> DISPATCH.
  - At edge e1, the first job's mult_start and disp_* become valid for exactly one cycle.
  - Maximum throughput is one job per cycle.
- Unit selection: the lowest index i with busy[i]=0 in the registered mask. Set busy[i] on dispatch.
- Walk order: col_i fastest, then row_i, then k. disp_row = row_i*S, disp_col = col_i*S. disp_idx increments by 1 per job.
- mult_done[i] with busy[i]=1 clears busy[i] at that edge and increments jobs_retired. The freed unit is eligible from the next edge; no same-cycle reuse.
- Multiple mult_done bits in one cycle are all retired together; jobs_retired adds popcount.
- mult_done[i] with busy[i]=0 is ignored for counting and sets err_spurious (sticky until next start).
- No free unit in DISPATCH: stall. mult_start stays 0 and counters hold.
- start while busy or in DONE: ignored.
- abort (any state other than IDLE): next state IDLE, busy mask cleared, no done pulse. jobs_retired holds its value. abort has priority over start.
- Reset mid-operation: immediate return to reset values. In-flight unit results are not tracked afterwards.
- Counter widths: truncation is not permitted. The parameter set must satisfy TOTAL < 2^IDX_W and N < 2^CW; instantiation asserts this.

Test Plan:
- Defaults, units answer mult_done 1 cycle after mult_start -> 108 mult_start pulses over contiguous cycles, alternating units 0/1. disp_idx runs 0..107. done pulses once, jobs_retired=108.
- Fixed unit latency 10 cycles, NMULT=8 -> first 8 jobs go to units 0..7 on consecutive cycles, then a stall until the first done. Steady state is 8 jobs per 11 cycles. done comes after the last retire; busy=0 with done.
- Channel/stride walk, N=8, S=2, K=2 -> OUT=3, TOTAL=18. Job 4 is (k=0,row=2,col=2); job 9 is (k=1,row=0,col=0).
- Simultaneous retires: units 2 and 5 pulse done in the same cycle -> jobs_retired +2. Next dispatch goes to unit 2, the one after that to unit 5.
- Spurious done on idle unit 7 during DISPATCH -> err_spurious=1 and stays set, jobs_retired unchanged. A new start clears the flag.
- abort at job 50, then rstn low mid-pass on a second run -> abort: IDLE next cycle, no done, busy=0. Reset: all outputs 0 immediately. A following start runs a full 108-job pass.

Source files
------------

// File: rtl/conv_mult_scheduler.sv
// conv_mult_scheduler: dispatches every window job of one convolution layer pass onto a pool of multiplier units
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   start, abort        begin a pass (IDLE only) / cancel the current pass
//   mult_done           per-unit one-cycle completion pulses
//   mult_start          one-hot one-cycle job launch, with disp_mid/k/row/col/idx describing the job
//   busy, done          pass in progress / one-cycle completion pulse
//   jobs_retired        completions accepted this pass
//   err_spurious        sticky flag: completion seen on a unit with no job outstanding
module conv_mult_scheduler #(
    parameter int N     = 8,
    parameter int F     = 3,
    parameter int S     = 1,
    parameter int K     = 3,
    parameter int NMULT = 8,
    parameter int MID_W = 3,
    parameter int CW    = 16,
    parameter int IDX_W = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [NMULT-1:0] mult_done,
    output logic [NMULT-1:0] mult_start,
    output logic [MID_W-1:0] disp_mid,
    output logic [CW-1:0]    disp_k,
    output logic [CW-1:0]    disp_row,
    output logic [CW-1:0]    disp_col,
    output logic [IDX_W-1:0] disp_idx,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] jobs_retired,
    output logic             err_spurious
);
    localparam int OUT = (N - F) / S + 1;
    localparam int TOTAL = OUT * OUT * K;
    localparam logic [CW-1:0] STEP = CW'(S);
    localparam logic [CW-1:0] LAST_POS = CW'((OUT - 1) * S);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    if (longint'(TOTAL) >= (64'd1 << IDX_W) || longint'(N) >= (64'd1 << CW) ||
        longint'(NMULT) > (64'd1 << MID_W)) begin : g_param_check
        $error("conv_mult_scheduler: parameter set overflows counter widths");
    end

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [NMULT-1:0]   bmask, retire, free_oh;
    logic [CW-1:0]      k_c, r_c, c_c;
    logic [IDX_W-1:0]   idx_c, n_ret;
    logic [MID_W-1:0]   free_id;
    logic               has_free, active, issue, col_wrap, row_wrap;

    // Lowest-indexed free unit; scanning downward lets the lowest index win.
    always_comb begin
        has_free = 1'b0;
        free_id  = '0;
        for (int i = NMULT - 1; i >= 0; i--) begin
            if (!bmask[i]) begin
                has_free = 1'b1;
                free_id  = MID_W'(i);
            end
        end
        free_oh = has_free ? (NMULT'(1) << free_id) : '0;
    end

    assign active   = state == DISPATCH || state == DRAIN;
    assign retire   = active ? (mult_done & bmask) : '0;
    assign issue    = state == DISPATCH && has_free && !abort;
    assign col_wrap = c_c == LAST_POS;
    assign row_wrap = r_c == LAST_POS;

    always_comb begin
        n_ret = '0;
        for (int i = 0; i < NMULT; i++) n_ret = n_ret + IDX_W'(retire[i]);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? DISPATCH : IDLE;
            DISPATCH: state_nx = (issue && idx_c == LAST_IDX) ? DRAIN : DISPATCH;
            DRAIN:    state_nx = (bmask == '0) ? DONE : DRAIN;
            default:  state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            bmask        <= '0;
            k_c          <= '0;
            r_c          <= '0;
            c_c          <= '0;
            idx_c        <= '0;
            mult_start   <= '0;
            disp_mid     <= '0;
            disp_k       <= '0;
            disp_row     <= '0;
            disp_col     <= '0;
            disp_idx     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            jobs_retired <= '0;
            err_spurious <= 1'b0;
        end else begin
            state      <= state_nx;
            busy       <= state_nx == DISPATCH || state_nx == DRAIN;
            done       <= state_nx == DONE;
            mult_start <= issue ? free_oh : '0;
            if (issue) begin
                disp_mid <= free_id;
                disp_k   <= k_c;
                disp_row <= r_c;
                disp_col <= c_c;
                disp_idx <= idx_c;
                idx_c    <= idx_c + 1'b1;
                c_c      <= col_wrap ? '0 : c_c + STEP;
                r_c      <= col_wrap ? (row_wrap ? '0 : r_c + STEP) : r_c;
                k_c      <= (col_wrap && row_wrap) ? k_c + 1'b1 : k_c;
            end
            if (state == IDLE && start && !abort) begin
                bmask        <= '0;
                k_c          <= '0;
                r_c          <= '0;
                c_c          <= '0;
                idx_c        <= '0;
                jobs_retired <= '0;
                err_spurious <= 1'b0;
            end else if (abort) begin
                // Abandoned jobs are forgotten; the retire count is left as it stood.
                bmask <= '0;
            end else begin
                // Retired and newly issued units are disjoint: issue only picks clear bits.
                bmask        <= (bmask & ~retire) | (issue ? free_oh : '0);
                jobs_retired <= jobs_retired + n_ret;
                if (active && |(mult_done & ~bmask)) err_spurious <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_mult_scheduler.sv
// tb_conv_mult_scheduler: directed checks of the convolution job dispatcher
module tb_conv_mult_scheduler;
    logic        clk = 1'b0;
    logic        rstn = 1'b0, start = 1'b0, abort = 1'b0, start2 = 1'b0;
    logic [7:0]  auto_done = '0, man_done = '0, mult_done, mult_start;
    logic [2:0]  disp_mid;
    logic [15:0] disp_k, disp_row, disp_col;
    logic [23:0] disp_idx, jobs_retired;
    logic        busy, done, err_spurious;
    logic [7:0]  ms2;
    logic [2:0]  mid2;
    logic [15:0] k2, row2, col2;
    logic [23:0] idx2, ret2;
    logic        busy2, done2, err2;

    always #5 clk = ~clk;
    assign mult_done = auto_done | man_done;

    conv_mult_scheduler dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mult_done(mult_done),
        .mult_start(mult_start), .disp_mid(disp_mid), .disp_k(disp_k), .disp_row(disp_row),
        .disp_col(disp_col), .disp_idx(disp_idx), .busy(busy), .done(done),
        .jobs_retired(jobs_retired), .err_spurious(err_spurious)
    );

    conv_mult_scheduler #(.N(8), .F(3), .S(2), .K(2)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .abort(1'b0), .mult_done(ms2),
        .mult_start(ms2), .disp_mid(mid2), .disp_k(k2), .disp_row(row2),
        .disp_col(col2), .disp_idx(idx2), .busy(busy2), .done(done2),
        .jobs_retired(ret2), .err_spurious(err2)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Dispatch log and fixed-latency unit model: a unit launched at edge t pulses done into edge t+lat.
    int cyc = 0, n_disp = 0, n_done = 0, lat = 0;
    int rem[8];
    int d_mid[1024], d_idx[1024], d_cyc[1024], d_k[1024], d_row[1024], d_col[1024];
    int d_oh[1024];
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mult_start != 0 && n_disp < 1024) begin
            d_mid[n_disp] = int'(disp_mid);
            d_idx[n_disp] = int'(disp_idx);
            d_k[n_disp]   = int'(disp_k);
            d_row[n_disp] = int'(disp_row);
            d_col[n_disp] = int'(disp_col);
            d_oh[n_disp]  = int'(mult_start);
            d_cyc[n_disp] = cyc;
            n_disp++;
        end
        if (done) n_done++;
        for (int i = 0; i < 8; i++) begin
            if (rem[i] > 0) rem[i]--;
            if (mult_start[i] && lat > 0) rem[i] = lat;
            auto_done[i] = rem[i] == 1;
        end
    end

    int u_k[32], u_r[32], u_c[32];
    int n2 = 0, nd2 = 0;
    always @(posedge clk) begin
        #1;
        if (ms2 != 0 && idx2 < 32) begin
            u_k[idx2] = int'(k2);
            u_r[idx2] = int'(row2);
            u_c[idx2] = int'(col2);
            n2++;
        end
        if (done2) nd2++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int nd0, input int budget);
        int t = 0;
        while (n_done == nd0 && t < budget) begin
            step(1);
            t++;
        end
        check({tag, "_finished"}, 64'(n_done > nd0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, nd0, c0, t;
        #3;
        check("rst_mult_start", mult_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", disp_idx, 0);
        check("rst_retired", jobs_retired, 0);
        check("rst_err", err_spurious, 0);
        step(2);
        rstn = 1'b1;
        step(1);

        // Latency 1: two units alternate, one job per cycle
        lat = 1; n0 = n_disp; nd0 = n_done;
        pulse_start();
        c0 = cyc;
        check("t1_busy", busy, 1);
        step(20);
        pulse_start();
        wait_done("t1", nd0, 400);
        check("t1_done", done, 1);
        check("t1_busy_at_done", busy, 0);
        check("t1_retired", jobs_retired, 108);
        check("t1_count", n_disp - n0, 108);
        check("t1_first_cycle", d_cyc[n0], c0 + 1);
        check("t1_contiguous", d_cyc[n0 + 107] - d_cyc[n0], 107);
        for (int j = 0; j < 108; j++) begin
            check($sformatf("t1_mid%0d", j), d_mid[n0 + j], j % 2);
            check($sformatf("t1_idx%0d", j), d_idx[n0 + j], j);
            check($sformatf("t1_oh%0d", j), d_oh[n0 + j], 1 << (j % 2));
        end
        check("t1_j7_row", d_row[n0 + 7], 1);
        check("t1_j7_col", d_col[n0 + 7], 1);
        check("t1_j36_k", d_k[n0 + 36], 1);
        check("t1_j107_k", d_k[n0 + 107], 2);
        check("t1_j107_row", d_row[n0 + 107], 5);
        step(3);
        check("t1_one_done", n_done - nd0, 1);
        check("t1_no_err", err_spurious, 0);

        // Latency 10: fill all 8 units, stall, then 8 jobs per 11 cycles
        lat = 10; n0 = n_disp; nd0 = n_done;
        pulse_start();
        wait_done("t2", nd0, 400);
        check("t2_count", n_disp - n0, 108);
        for (int j = 0; j < 108; j++) begin
            check($sformatf("t2_mid%0d", j), d_mid[n0 + j], j % 8);
            check($sformatf("t2_cyc%0d", j), d_cyc[n0 + j] - d_cyc[n0], (j / 8) * 11 + j % 8);
        end
        check("t2_done_cycle", cyc - d_cyc[n0], 157);
        check("t2_busy_at_done", busy, 0);
        check("t2_retired", jobs_retired, 108);

        // Stride 2, two channels: OUT=3, 18 jobs
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        t = 0;
        while (nd2 == 0 && t < 200) begin
            step(1);
            t++;
        end
        check("t3_finished", 64'(nd2 > 0), 1);
        check("t3_count", n2, 18);
        check("t3_retired", ret2, 18);
        check("t3_j1_col", u_c[1], 2);
        check("t3_j4_k", u_k[4], 0);
        check("t3_j4_row", u_r[4], 2);
        check("t3_j4_col", u_c[4], 2);
        check("t3_j9_k", u_k[9], 1);
        check("t3_j9_row", u_r[9], 0);
        check("t3_j9_col", u_c[9], 0);
        check("t3_j17_row", u_r[17], 4);
        check("t3_j17_col", u_c[17], 4);

        // Manual completions: spurious done on idle unit 7, then simultaneous retires
        step(15);
        lat = 0; n0 = n_disp; nd0 = n_done;
        pulse_start();
        man_done = 8'h80;
        step(1);
        man_done = 8'h00;
        check("t5_err_set", err_spurious, 1);
        check("t5_retired", jobs_retired, 0);
        step(10);
        check("t4_filled", n_disp - n0, 8);
        check("t4_unit7", d_mid[n0 + 7], 7);
        check("t4_stall_start", mult_start, 0);
        check("t4_stall_idx", disp_idx, 7);
        man_done = 8'h24;
        step(1);
        man_done = 8'h00;
        check("t4_retired2", jobs_retired, 2);
        check("t4_no_reuse", mult_start, 0);
        step(1);
        check("t4_next_oh", mult_start, 8'h04);
        check("t4_next_mid", disp_mid, 2);
        check("t4_next_idx", disp_idx, 8);
        step(1);
        check("t4_after_oh", mult_start, 8'h20);
        check("t4_after_mid", disp_mid, 5);
        check("t4_after_idx", disp_idx, 9);
        step(1);
        check("t4_stall_again", mult_start, 0);
        check("t5_err_sticky", err_spurious, 1);
        check("t5_retired_hold", jobs_retired, 2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_done", done, 0);
        check("t4_abort_retired", jobs_retired, 2);
        step(3);
        check("t4_abort_no_done", n_done - nd0, 0);
        pulse_start();
        check("t5_err_cleared", err_spurious, 0);
        check("t5_restart_busy", busy, 1);
        check("t5_retired_cleared", jobs_retired, 0);
        abort = 1'b1;
        step(1);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_no_issue", mult_start, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_beats_start", busy, 0);

        // Abort at job 50
        lat = 1; nd0 = n_done;
        pulse_start();
        t = 0;
        while (!(mult_start != 0 && disp_idx == 50) && t < 200) begin
            step(1);
            t++;
        end
        check("t6_reached_50", 64'(t < 200), 1);
        check("t6_retired_before", jobs_retired, 50);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_start", mult_start, 0);
        check("t6_done", done, 0);
        check("t6_retired_hold", jobs_retired, 50);
        step(5);
        check("t6_no_done", n_done - nd0, 0);
        check("t6_retired_idle", jobs_retired, 50);

        // Asynchronous reset mid-pass, then a full pass
        pulse_start();
        step(20);
        #1;
        rstn = 1'b0;
        #1;
        check("t7_rst_start", mult_start, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_idx", disp_idx, 0);
        check("t7_rst_mid", disp_mid, 0);
        check("t7_rst_retired", jobs_retired, 0);
        check("t7_rst_done", done, 0);
        step(2);
        rstn = 1'b1;
        step(3);
        n0 = n_disp; nd0 = n_done;
        pulse_start();
        wait_done("t7", nd0, 400);
        check("t7_count", n_disp - n0, 108);
        check("t7_retired", jobs_retired, 108);
        check("t7_last_idx", d_idx[n0 + 107], 107);
        check("t7_err", err_spurious, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
